// File: rtl/iobuf_bus_seq.sv
// Bidirectional pad bus sequencer: single-word write/read commands over valid/ready,
// with tristated turnaround on direction change and programmable read settle time.

module iobuf #(
    parameter int DRIVE        = 12,
    parameter     IBUF_LOW_PWR = "TRUE",
    parameter     IOSTANDARD   = "DEFAULT",
    parameter     SLEW         = "SLOW"
) (
    output logic o,
    inout  logic io,
    input  logic i,
    input  logic t
);
    // Buffer attributes only matter to vendor mapping; the behavioural pad drives whenever configured.
    localparam int ATTR_BITS = $bits(IBUF_LOW_PWR) + $bits(IOSTANDARD) + $bits(SLEW);

    generate
        if (DRIVE > 0 && ATTR_BITS > 0) begin : g_drive
            assign io = t ? 1'bz : i;
        end else begin : g_hiz
            assign io = 1'bz;
        end
    endgenerate

    assign o = io;
endmodule

module iobuf_bus_seq #(
    parameter int WIDTH        = 8,
    parameter int TURN_CYCLES  = 1,
    parameter int READ_DELAY   = 2,
    parameter int DRIVE        = 12,
    parameter     IBUF_LOW_PWR = "TRUE",
    parameter     IOSTANDARD   = "DEFAULT",
    parameter     SLEW         = "SLOW"
) (
    input  logic             mclk,
    input  logic             mrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             bus_dir,
    inout  logic [WIDTH-1:0] io
);
    typedef enum logic [1:0] {IDLE, TURN, XFER, WAIT} state_t;

    localparam logic [3:0] TURN_M1 = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] RD_M1   = 4'(READ_DELAY - 1);

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             we_r;
    logic [WIDTH-1:0] wdata_r;
    logic [WIDTH-1:0] out_r;
    logic             tri_r;
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] in_r;
    logic             accept;
    logic             enter_turn, enter_xfer, enter_wait, capture;
    logic [WIDTH-1:0] xfer_data;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_turn = 1'b0;
        enter_xfer = 1'b0;
        enter_wait = 1'b0;
        capture    = 1'b0;
        xfer_data  = wdata_r;
        case (state)
            IDLE: begin
                xfer_data = cmd_wdata;
                if (cmd_valid) begin
                    if ((cmd_we != bus_dir) && (TURN_CYCLES != 0)) begin
                        state_nx   = TURN;
                        cnt_nx     = TURN_M1;
                        enter_turn = 1'b1;
                    end else if (cmd_we) begin
                        state_nx   = XFER;
                        enter_xfer = 1'b1;
                    end else begin
                        state_nx   = WAIT;
                        cnt_nx     = RD_M1;
                        enter_wait = 1'b1;
                    end
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    if (we_r) begin
                        state_nx   = XFER;
                        enter_xfer = 1'b1;
                    end else begin
                        state_nx   = WAIT;
                        cnt_nx     = RD_M1;
                        enter_wait = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            XFER: state_nx = IDLE;
            WAIT: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (mrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Pad controls are registered on state entry so drive/release lines up with the new state.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            we_r     <= 1'b0;
            wdata_r  <= '0;
            out_r    <= '0;
            tri_r    <= 1'b1;
            bus_dir  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= capture;
            if (accept) begin
                we_r    <= cmd_we;
                wdata_r <= cmd_wdata;
            end
            if (enter_turn || enter_wait) begin
                tri_r   <= 1'b1;
                bus_dir <= 1'b0;
            end
            if (enter_xfer) begin
                out_r   <= xfer_data;
                tri_r   <= 1'b0;
                bus_dir <= 1'b1;
            end
            if (capture) begin
                rd_data <= in_r;
            end
        end
    end

    always_ff @(posedge mclk) begin
        in_r <= pad_in;
    end

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_pad
            iobuf #(
                .DRIVE       (DRIVE),
                .IBUF_LOW_PWR(IBUF_LOW_PWR),
                .IOSTANDARD  (IOSTANDARD),
                .SLEW        (SLEW)
            ) u_iobuf (
                .o (pad_in[b]),
                .io(io[b]),
                .i (out_r[b]),
                .t (tri_r)
            );
        end
    endgenerate
endmodule

// File: tb/tb_iobuf_bus_seq.sv
// Bench for iobuf_bus_seq: directed vector table, reset corner sequences, and a
// randomized run against a cycle-timeline reference model.

module tb_iobuf_bus_seq;
    localparam int W     = 8;
    localparam int TURN  = 1;
    localparam int RD    = 2;
    localparam int NCYC  = 1500;
    localparam int NARR  = NCYC + TURN + RD + 8;

    logic         mclk;
    logic         mrst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_we;
    logic [W-1:0] cmd_wdata;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         bus_dir;
    wire  [W-1:0] io;
    logic         ext_en;
    logic [W-1:0] ext_val;

    int total;
    int bad;

    assign io = ext_en ? ext_val : 'z;

    iobuf_bus_seq #(
        .WIDTH      (W),
        .TURN_CYCLES(TURN),
        .READ_DELAY (RD)
    ) dut (
        .mclk     (mclk),
        .mrst     (mrst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_wdata(cmd_wdata),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .bus_dir  (bus_dir),
        .io       (io)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic         v;
        logic         we;
        logic [W-1:0] wd;
        logic         ee;
        logic [W-1:0] ev;
        logic         r;
        logic         d;
        logic [W-1:0] io;
        logic         rv;
        logic [W-1:0] rd;
    } vec_t;

    vec_t tbl [19];

    // One cycle of stimulus applied at the falling edge; outputs sampled 1 time unit later.
    task automatic step(input logic rst, input logic v, input logic we, input logic [W-1:0] wd,
                        input logic ee, input logic [W-1:0] ev);
        @(negedge mclk);
        mrst      = rst;
        cmd_valid = v;
        cmd_we    = we;
        cmd_wdata = wd;
        ext_en    = ee;
        ext_val   = ev;
        #1;
    endtask

    logic         m_dir [NARR];
    logic [W-1:0] m_val [NARR];
    logic         m_rdv [NARR];
    logic [W-1:0] m_pad [NARR];
    int           ready_at;
    int           turn;
    logic [W-1:0] rd_hold;
    logic         rv_in, we_in;
    logic [W-1:0] wd_in;

    initial begin
        total = 0;
        bad   = 0;
        mrst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_wdata = '0;
        ext_en = 1'b1; ext_val = '0;

        //             v  we  wd     ee  ev      r  d  io     rv  rd
        tbl[0]  = '{1'b0,1'b0,8'h00,1'b1,8'h77, 1'b1,1'b0,8'h77,1'b0,8'h00};
        tbl[1]  = '{1'b0,1'b0,8'h00,1'b1,8'h77, 1'b1,1'b0,8'h77,1'b0,8'h00};
        tbl[2]  = '{1'b1,1'b1,8'hA5,1'b1,8'h77, 1'b1,1'b0,8'h77,1'b0,8'h00};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b1,8'h66, 1'b0,1'b0,8'h66,1'b0,8'h00};
        tbl[4]  = '{1'b1,1'b1,8'hFF,1'b0,8'h00, 1'b0,1'b1,8'hA5,1'b0,8'h00};
        tbl[5]  = '{1'b1,1'b1,8'h3C,1'b0,8'h00, 1'b1,1'b1,8'hA5,1'b0,8'h00};
        tbl[6]  = '{1'b0,1'b0,8'h00,1'b0,8'h00, 1'b0,1'b1,8'h3C,1'b0,8'h00};
        tbl[7]  = '{1'b1,1'b0,8'h00,1'b0,8'h00, 1'b1,1'b1,8'h3C,1'b0,8'h00};
        tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,8'h5A, 1'b0,1'b0,8'h5A,1'b0,8'h00};
        tbl[9]  = '{1'b1,1'b1,8'hEE,1'b1,8'h5A, 1'b0,1'b0,8'h5A,1'b0,8'h00};
        tbl[10] = '{1'b0,1'b0,8'h00,1'b1,8'h5A, 1'b0,1'b0,8'h5A,1'b0,8'h00};
        tbl[11] = '{1'b1,1'b0,8'h00,1'b1,8'h11, 1'b1,1'b0,8'h11,1'b1,8'h5A};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b1,8'h11, 1'b0,1'b0,8'h11,1'b0,8'h5A};
        tbl[13] = '{1'b0,1'b0,8'h00,1'b1,8'h11, 1'b0,1'b0,8'h11,1'b0,8'h5A};
        tbl[14] = '{1'b1,1'b0,8'h00,1'b1,8'h22, 1'b1,1'b0,8'h22,1'b1,8'h11};
        tbl[15] = '{1'b0,1'b0,8'h00,1'b1,8'h22, 1'b0,1'b0,8'h22,1'b0,8'h11};
        tbl[16] = '{1'b0,1'b0,8'h00,1'b1,8'h22, 1'b0,1'b0,8'h22,1'b0,8'h11};
        tbl[17] = '{1'b0,1'b0,8'h00,1'b1,8'h22, 1'b1,1'b0,8'h22,1'b1,8'h22};
        tbl[18] = '{1'b0,1'b0,8'h00,1'b1,8'h33, 1'b1,1'b0,8'h33,1'b0,8'h22};

        repeat (3) @(posedge mclk);

        for (int i = 0; i < 19; i++) begin
            step(1'b0, tbl[i].v, tbl[i].we, tbl[i].wd, tbl[i].ee, tbl[i].ev);
            chk($sformatf("vec%0d.ready", i), 8'(cmd_ready), 8'(tbl[i].r));
            chk($sformatf("vec%0d.dir", i),   8'(bus_dir),   8'(tbl[i].d));
            chk($sformatf("vec%0d.io", i),    io,            tbl[i].io);
            chk($sformatf("vec%0d.rv", i),    8'(rd_valid),  8'(tbl[i].rv));
            chk($sformatf("vec%0d.rd", i),    rd_data,       tbl[i].rd);
        end

        // Reset while the bus is driven: pads must release on the reset edge.
        step(1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rstdrv.io_before", io, 8'hC3);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("rstdrv.dir_in_rst", 8'(bus_dir), 8'h01);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96);
        chk("rstdrv.dir_after", 8'(bus_dir), 8'h00);
        chk("rstdrv.io_after",  io, 8'h96);
        chk("rstdrv.ready",     8'(cmd_ready), 8'h01);
        chk("rstdrv.rd_clear",  rd_data, 8'h00);

        // Reset in the capture cycle of WAIT: no read result may escape.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h44);
        chk("rstwait.ready_busy", 8'(cmd_ready), 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h44);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h44);
            chk("rstwait.rv",    8'(rd_valid), 8'h00);
            chk("rstwait.rd",    rd_data, 8'h00);
            chk("rstwait.ready", 8'(cmd_ready), 8'h01);
            chk("rstwait.io",    io, 8'h44);
        end

        // Randomized run against a timeline model: each accepted command rewrites
        // the expected bus direction/value from the next cycle onward.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        for (int j = 0; j < NARR; j++) begin
            m_dir[j] = 1'b0;
            m_val[j] = '0;
            m_rdv[j] = 1'b0;
            m_pad[j] = '0;
        end
        ready_at = 0;
        rd_hold  = '0;

        for (int k = 0; k < NCYC; k++) begin
            rv_in = ($urandom_range(9) < 6);
            we_in = 1'($urandom);
            wd_in = 8'($urandom);
            step(1'b0, rv_in, we_in, wd_in, !m_dir[k], 8'($urandom));
            m_pad[k] = m_dir[k] ? m_val[k] : ext_val;
            if (m_rdv[k]) rd_hold = m_pad[k-2];
            chk("rnd.ready", 8'(cmd_ready), 8'(k >= ready_at));
            chk("rnd.dir",   8'(bus_dir),   8'(m_dir[k]));
            chk("rnd.io",    io,            m_pad[k]);
            chk("rnd.rv",    8'(rd_valid),  8'(m_rdv[k]));
            chk("rnd.rd",    rd_data,       rd_hold);
            if (rv_in && k >= ready_at) begin
                turn = (we_in != m_dir[k]) ? TURN : 0;
                if (we_in) begin
                    for (int j = k + 1; j < NARR; j++) begin
                        m_dir[j] = (j > k + turn);
                        m_val[j] = wd_in;
                    end
                    ready_at = k + turn + 2;
                end else begin
                    for (int j = k + 1; j < NARR; j++) m_dir[j] = 1'b0;
                    m_rdv[k + turn + RD + 1] = 1'b1;
                    ready_at = k + turn + RD + 1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
